// File: rtl/timebase_ctrl_if.sv
// Bus between front-panel command logic and timebase_ctrl.
// sq_o is present only when TIMEBASE_SQ_EN is defined.
interface timebase_ctrl_if #(
   parameter int CNT_W     = 30,
   parameter int TICKCNT_W = 16
);
   logic                 cmd_start_i;
   logic                 cmd_stop_i;
   logic                 cmd_step_i;
   logic                 cmd_clear_i;
   logic [CNT_W-1:0]     div_i;
   logic                 div_valid_i;
   logic                 div_ready_o;
   logic                 tick_o;
   logic [TICKCNT_W-1:0] tick_count_o;
   logic [1:0]           state_o;
   logic                 busy_o;
`ifdef TIMEBASE_SQ_EN
   logic                 sq_o;

   modport master (
      output cmd_start_i, cmd_stop_i, cmd_step_i, cmd_clear_i, div_i, div_valid_i,
      input  div_ready_o, tick_o, tick_count_o, state_o, busy_o, sq_o
   );
   modport slave (
      input  cmd_start_i, cmd_stop_i, cmd_step_i, cmd_clear_i, div_i, div_valid_i,
      output div_ready_o, tick_o, tick_count_o, state_o, busy_o, sq_o
   );
`else
   modport master (
      output cmd_start_i, cmd_stop_i, cmd_step_i, cmd_clear_i, div_i, div_valid_i,
      input  div_ready_o, tick_o, tick_count_o, state_o, busy_o
   );
   modport slave (
      input  cmd_start_i, cmd_stop_i, cmd_step_i, cmd_clear_i, div_i, div_valid_i,
      output div_ready_o, tick_o, tick_count_o, state_o, busy_o
   );
`endif
endinterface

// File: rtl/timebase_ctrl.sv
// Run/stop/step timebase: emits one-cycle tick strobes every div_r cycles.
// Optional square-wave output sq_o is enabled by defining TIMEBASE_SQ_EN.
//
// state | meaning
// IDLE  | stopped, phase cleared; pending divisor applied immediately
// RUN   | free-running, tick every div_r cycles
// PAUSE | stopped, phase held; pending divisor applied immediately
// STEP  | run one period, then fall back to PAUSE
module timebase_ctrl #(
   parameter int CNT_W       = 30,
   parameter int DIV_DEFAULT = 100000000,
   parameter int TICKCNT_W   = 16
) (
   input  logic          clk_i,
   input  logic          reset,
   timebase_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      STEP  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]     DIV_RST = CNT_W'(DIV_DEFAULT);
   localparam logic [CNT_W-1:0]     ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]     TWO     = CNT_W'(2);
   localparam logic [TICKCNT_W-1:0] TC_ONE  = TICKCNT_W'(1);

   state_t               state, nxt_state;
   logic [CNT_W-1:0]     phase, nxt_phase;
   logic [CNT_W-1:0]     div_r, nxt_div;
   logic [CNT_W-1:0]     pend_div;
   logic                 pend_full;
   logic [TICKCNT_W-1:0] tick_count, nxt_count;
   logic                 tick_r, nxt_tick;
   logic                 busy_r;
   logic                 active, count_en, apply, xfer;

   assign active = (state == RUN) || (state == STEP);
   assign xfer   = bus.div_valid_i && !pend_full;

   always_comb begin
      nxt_state = state;
      nxt_phase = phase;
      nxt_div   = div_r;
      nxt_count = tick_count;
      nxt_tick  = 1'b0;
      apply     = 1'b0;
      count_en  = 1'b0;
      if (bus.cmd_clear_i) begin
         nxt_state = IDLE;
         nxt_phase = '0;
         nxt_count = '0;
      end else begin
         count_en = active;
         if (bus.cmd_stop_i) begin
            unique case (state)
               RUN, STEP: begin
                  nxt_state = PAUSE;
                  count_en  = 1'b0;
               end
               PAUSE: begin
                  nxt_state = IDLE;
                  nxt_phase = '0;
               end
               default: ;
            endcase
         end else if (bus.cmd_start_i) begin
            nxt_state = RUN;
         end else if (bus.cmd_step_i) begin
            if (!active) nxt_state = STEP;
         end

         if (count_en) begin
            if (phase == div_r - ONE) begin
               nxt_phase = '0;
               nxt_tick  = 1'b1;
               nxt_count = tick_count + TC_ONE;
               if (nxt_state == STEP) nxt_state = PAUSE;
               if (pend_full) begin
                  nxt_div = pend_div;
                  apply   = 1'b1;
               end
            end else begin
               nxt_phase = phase + ONE;
            end
         end else if (!active && pend_full) begin
            // Stopped: a new divisor restarts the period from zero.
            nxt_div   = pend_div;
            nxt_phase = '0;
            apply     = 1'b1;
         end
      end
   end

`ifdef TIMEBASE_SQ_EN
   logic sq_r;
   assign bus.sq_o = sq_r;
`endif

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         phase      <= '0;
         div_r      <= DIV_RST;
         pend_div   <= DIV_RST;
         pend_full  <= 1'b0;
         tick_count <= '0;
         tick_r     <= 1'b0;
         busy_r     <= 1'b0;
`ifdef TIMEBASE_SQ_EN
         sq_r       <= 1'b0;
`endif
      end else begin
         state      <= nxt_state;
         phase      <= nxt_phase;
         div_r      <= nxt_div;
         tick_count <= nxt_count;
         tick_r     <= nxt_tick;
         busy_r     <= (nxt_state == RUN) || (nxt_state == STEP);
`ifdef TIMEBASE_SQ_EN
         sq_r       <= (nxt_state != IDLE) && (nxt_phase < (nxt_div >> 1));
`endif
         if (xfer) begin
            pend_div  <= (bus.div_i < TWO) ? TWO : bus.div_i;
            pend_full <= 1'b1;
         end else if (apply) begin
            pend_full <= 1'b0;
         end
      end
   end

   assign bus.div_ready_o  = !pend_full;
   assign bus.tick_o       = tick_r;
   assign bus.tick_count_o = tick_count;
   assign bus.state_o      = state;
   assign bus.busy_o       = busy_r;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Self-checking bench for timebase_ctrl: FSM command table plus tick scoreboard.
module tb_timebase_ctrl;

   localparam int CNT_W = 30;
   localparam int TCW   = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   exp_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   timebase_ctrl_if #(.CNT_W(CNT_W), .TICKCNT_W(TCW)) bus ();

   timebase_ctrl #(.CNT_W(CNT_W), .DIV_DEFAULT(100000000), .TICKCNT_W(TCW)) dut (
      .clk_i (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int cyc;
      int cnt;
   } tick_exp_t;

   tick_exp_t exp_q[$];

   typedef struct {
      logic       start;
      logic       stop;
      logic       step;
      logic       clear;
      logic [1:0] st;
      logic       busy;
   } vec_t;

   vec_t vecs [0:17];

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard: every observed tick must match the head of the queue.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         total++;
         bad++;
         $display("FAIL missed_tick: got none, want tick at cycle %0d", exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (bus.tick_o) begin
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check("tick_time", cyc, exp_q[0].cyc);
            check("tick_count", int'(bus.tick_count_o), exp_q[0].cnt);
            void'(exp_q.pop_front());
         end else begin
            check("unexpected_tick", 1, 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic push_tick(input int at);
      tick_exp_t e;
      exp_cnt = (exp_cnt + 1) % (1 << TCW);
      e.cyc = at;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
   endtask

   // Drive one command cycle; returns the cycle number of the sampling edge.
   task automatic cmd(input logic s, input logic t, input logic p, input logic c, output int edge_cyc);
      bus.cmd_start_i = s;
      bus.cmd_stop_i  = t;
      bus.cmd_step_i  = p;
      bus.cmd_clear_i = c;
      @(negedge clk);
      edge_cyc = cyc;
      bus.cmd_start_i = 1'b0;
      bus.cmd_stop_i  = 1'b0;
      bus.cmd_step_i  = 1'b0;
      bus.cmd_clear_i = 1'b0;
   endtask

   task automatic run_until(input int c);
      for (int i = 0; i < 1000 && cyc < c; i++) @(negedge clk);
   endtask

   task automatic do_clear();
      int e;
      cmd(1'b0, 1'b0, 1'b0, 1'b1, e);
      exp_cnt = 0;
   endtask

   // Load a divisor while stopped; it is applied on the following edge.
   task automatic load_div(input int d);
      bus.div_i = CNT_W'(d);
      bus.div_valid_i = 1'b1;
      for (int i = 0; i < 20 && !bus.div_ready_o; i++) @(negedge clk);
      check("div_ready_offer", int'(bus.div_ready_o), 1);
      @(negedge clk);
      bus.div_valid_i = 1'b0;
      check("div_ready_held", int'(bus.div_ready_o), 0);
      @(negedge clk);
      check("div_ready_applied", int'(bus.div_ready_o), 1);
   endtask

   initial begin
      int s;
      int e;
      bus.cmd_start_i = 1'b0;
      bus.cmd_stop_i  = 1'b0;
      bus.cmd_step_i  = 1'b0;
      bus.cmd_clear_i = 1'b0;
      bus.div_i       = '0;
      bus.div_valid_i = 1'b0;

      //           start stop step clear state busy
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};

      repeat (3) @(negedge clk);
      check("rst_state", int'(bus.state_o), 0);
      check("rst_busy", int'(bus.busy_o), 0);
      check("rst_tick", int'(bus.tick_o), 0);
      check("rst_count", int'(bus.tick_count_o), 0);
      check("rst_ready", int'(bus.div_ready_o), 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Command table, run at the 100M reset divisor so no ticks occur.
      for (int i = 0; i < 18; i++) begin
         cmd(vecs[i].start, vecs[i].stop, vecs[i].step, vecs[i].clear, e);
         check($sformatf("vec%0d_state", i), int'(bus.state_o), int'(vecs[i].st));
         check($sformatf("vec%0d_busy", i), int'(bus.busy_o), int'(vecs[i].busy));
      end
      exp_cnt = 0;

      // Basic run at divisor 4.
      load_div(4);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      push_tick(s + 4);
      push_tick(s + 8);
      push_tick(s + 12);
      run_until(s + 10);
      check("run_busy", int'(bus.busy_o), 1);
      run_until(s + 13);
      check("run_q_empty", exp_q.size(), 0);
      do_clear();

      // Single step at divisor 5.
      load_div(5);
      cmd(1'b0, 1'b0, 1'b1, 1'b0, s);
      check("step_state", int'(bus.state_o), 3);
      push_tick(s + 5);
      run_until(s + 4);
      check("step_state_pre", int'(bus.state_o), 3);
      run_until(s + 5);
      check("step_state_post", int'(bus.state_o), 2);
      check("step_busy_post", int'(bus.busy_o), 0);
      run_until(s + 25);
      check("step_state_idle", int'(bus.state_o), 2);
      check("step_q_empty", exp_q.size(), 0);
      do_clear();

      // Divisor change mid-run: 8 -> 3 at phase 2.
      load_div(8);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      push_tick(s + 8);
      push_tick(s + 11);
      push_tick(s + 14);
      run_until(s + 2);
      bus.div_i = CNT_W'(3);
      bus.div_valid_i = 1'b1;
      check("chg_ready_offer", int'(bus.div_ready_o), 1);
      @(negedge clk);
      bus.div_valid_i = 1'b0;
      check("chg_ready_low", int'(bus.div_ready_o), 0);
      run_until(s + 7);
      check("chg_ready_prewrap", int'(bus.div_ready_o), 0);
      run_until(s + 8);
      check("chg_ready_wrap", int'(bus.div_ready_o), 1);
      run_until(s + 15);
      check("chg_q_empty", exp_q.size(), 0);
      do_clear();

      // Pause at phase 6 of 10, resume, then stop twice.
      load_div(10);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      run_until(s + 6);
      cmd(1'b0, 1'b1, 1'b0, 1'b0, e);
      check("pause_state", int'(bus.state_o), 2);
      repeat (15) @(negedge clk);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      push_tick(s + 4);
      run_until(s + 5);
      cmd(1'b0, 1'b1, 1'b0, 1'b0, e);
      check("pause2_state", int'(bus.state_o), 2);
      cmd(1'b0, 1'b1, 1'b0, 1'b0, e);
      check("stop2_state", int'(bus.state_o), 0);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      push_tick(s + 10);
      run_until(s + 11);
      check("resume_q_empty", exp_q.size(), 0);
      do_clear();

      // Clear on the wrap cycle suppresses the tick.
      load_div(4);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      push_tick(s + 4);
      run_until(s + 7);
      cmd(1'b0, 1'b0, 1'b0, 1'b1, e);
      exp_cnt = 0;
      check("clrwrap_tick", int'(bus.tick_o), 0);
      check("clrwrap_count", int'(bus.tick_count_o), 0);
      check("clrwrap_state", int'(bus.state_o), 0);

      // Asynchronous reset mid-period with a divisor pending.
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      run_until(s + 2);
      bus.div_i = CNT_W'(7);
      bus.div_valid_i = 1'b1;
      @(negedge clk);
      bus.div_valid_i = 1'b0;
      check("rstmid_ready_pre", int'(bus.div_ready_o), 0);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_state", int'(bus.state_o), 0);
      check("rstmid_busy", int'(bus.busy_o), 0);
      check("rstmid_tick", int'(bus.tick_o), 0);
      check("rstmid_count", int'(bus.tick_count_o), 0);
      check("rstmid_ready", int'(bus.div_ready_o), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      @(negedge clk);

      // Divisor 0 clamps to 2; 16 ticks wrap the 4-bit counter to 0.
      load_div(0);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      for (int k = 1; k <= 16; k++) push_tick(s + 2 * k);
      run_until(s + 33);
      check("wrap_q_empty", exp_q.size(), 0);
      check("wrap_count", int'(bus.tick_count_o), 0);
      do_clear();

`ifdef TIMEBASE_SQ_EN
      check("sq_idle", int'(bus.sq_o), 0);
      load_div(6);
      cmd(1'b1, 1'b0, 1'b0, 1'b0, s);
      push_tick(s + 6);
      push_tick(s + 12);
      for (int k = 0; k < 12; k++) begin
         run_until(s + k);
         check($sformatf("sq_k%0d", k), int'(bus.sq_o), ((k % 6) < 3) ? 1 : 0);
      end
      run_until(s + 13);
      check("sq_q_empty", exp_q.size(), 0);
      do_clear();
      check("sq_clear", int'(bus.sq_o), 0);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
